prng_arb_ctrl: RTL and testbench

PRNG_ARB_CTRL -- requirements
Module: prng_arb_ctrl

---
 rtl/prng_arb_ctrl.sv | 114 +++++++++++
 tb/tb_prng_arb_ctrl.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/prng_arb_ctrl.sv
// rtl/prng_arb_ctrl.sv - two-requester round-robin arbiter delivering LFSR-mixed random bytes
//
// Ports:
//   clk        - single clock, all state on rising edge
//   rst_n      - synchronous active-low reset
//   seed_we    - seed load strobe (honoured in IDLE only)
//   seed_data  - 16-bit seed; L8 seeded from the xor of its two bytes
//   req[1:0]   - per-requester byte request, level held until ack
//   ack[1:0]   - one-hot, one-cycle grant-complete pulse
//   rnd_out    - delivered random byte, held between deliveries
//   rnd_valid  - high together with any ack bit
//   busy       - high whenever the FSM is not in IDLE
module prng_arb_ctrl #(
  parameter int STEPS = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        seed_we,
  input  logic [15:0] seed_data,
  input  logic [1:0]  req,
  output logic [1:0]  ack,
  output logic [7:0]  rnd_out,
  output logic        rnd_valid,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, STEP, DONE} state_t;

  state_t      state, state_nxt;
  logic [15:0] l16;
  logic [7:0]  l8;
  logic [7:0]  cnt;
  logic        grantee;
  logic        last_grant;

  logic        fb16, fb8;
  logic [15:0] l16_sh;
  logic [7:0]  l8_sh;
  logic [7:0]  seed_x;
  logic        pick;
  logic        last_step;

  // XNOR feedback: the all-ones word is the lock-up value, so all-zeros is a legal start.
  assign fb16   = ~(l16[15] ^ l16[14] ^ l16[12] ^ l16[3]);
  assign fb8    = ~(l8[7] ^ l8[5] ^ l8[4] ^ l8[3]);
  assign l16_sh = {l16[14:0], fb16};
  assign l8_sh  = {l8[6:0], fb8};
  assign seed_x = seed_data[15:8] ^ seed_data[7:0];

  // Tie goes to the requester that did not win last; otherwise the lone requester.
  assign pick      = (req == 2'b11) ? ~last_grant : req[1];
  assign last_step = (cnt == 8'(STEPS - 1));

  // L8 selects, per output bit, one of two adjacent L16 bits.
  function automatic logic [7:0] mix(input logic [15:0] a, input logic [7:0] s);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) begin
      r[i] = s[i] ? a[2*i+1] : a[2*i];
    end
    return r;
  endfunction

  always_comb begin
    state_nxt = state;
    ack       = 2'b00;
    rnd_valid = 1'b0;
    busy      = (state != IDLE);
    case (state)
      IDLE: if (!seed_we && (req != 2'b00)) state_nxt = STEP;
      STEP: if (last_step) state_nxt = DONE;
      DONE: begin
        state_nxt = IDLE;
        ack       = grantee ? 2'b10 : 2'b01;
        rnd_valid = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      l16        <= 16'h0000;
      l8         <= 8'h00;
      cnt        <= 8'd0;
      rnd_out    <= 8'h00;
      grantee    <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (seed_we) begin
            l16 <= (seed_data == 16'hFFFF) ? 16'h0000 : seed_data;
            l8  <= (seed_x == 8'hFF) ? 8'h00 : seed_x;
          end else if (req != 2'b00) begin
            grantee <= pick;
            cnt     <= 8'd0;
          end
        end
        STEP: begin
          l16 <= l16_sh;
          l8  <= l8_sh;
          cnt <= cnt + 8'd1;
          // Capture from the post-shift values so the byte is on rnd_out while DONE acks.
          if (last_step) rnd_out <= mix(l16_sh, l8_sh);
        end
        DONE: last_grant <= grantee;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_prng_arb_ctrl.sv
// tb/tb_prng_arb_ctrl.sv - randomized bench for prng_arb_ctrl at STEPS=8 and STEPS=1
module tb_prng_arb_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        seed_we;
  logic [15:0] seed_data;
  logic [1:0]  req;

  logic [1:0]  ack_a, ack_b;
  logic [7:0]  rnd_a, rnd_b;
  logic        val_a, val_b, busy_a, busy_b;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  prng_arb_ctrl #(.STEPS(8)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .seed_we(seed_we), .seed_data(seed_data), .req(req),
    .ack(ack_a), .rnd_out(rnd_a), .rnd_valid(val_a), .busy(busy_a)
  );

  prng_arb_ctrl #(.STEPS(1)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .seed_we(seed_we), .seed_data(seed_data), .req(req),
    .ack(ack_b), .rnd_out(rnd_b), .rnd_valid(val_b), .busy(busy_b)
  );

  // Transaction-level reference: a grant immediately advances the model LFSRs by
  // the full step count and remembers the resulting byte; a countdown of the
  // cycles left until IDLE decides when ack, rnd_valid and busy are expected.
  int          m_steps [2] = '{8, 1};
  logic [15:0] m16     [2];
  logic [7:0]  m8      [2];
  int          m_rem   [2];
  logic        m_g     [2];
  logic        m_last  [2];
  logic [7:0]  m_out   [2];
  logic [7:0]  m_pend  [2];

  function automatic logic [15:0] adv16(input logic [15:0] v);
    return {v[14:0], ~(v[15] ^ v[14] ^ v[12] ^ v[3])};
  endfunction

  function automatic logic [7:0] adv8(input logic [7:0] v);
    return {v[6:0], ~(v[7] ^ v[5] ^ v[4] ^ v[3])};
  endfunction

  function automatic logic [7:0] form_byte(input logic [15:0] a, input logic [7:0] s);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = a[2*i + s[i]];
    return r;
  endfunction

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        m16[k] = 16'h0000; m8[k] = 8'h00; m_rem[k] = 0; m_out[k] = 8'h00;
        m_last[k] = 1'b1; m_g[k] = 1'b0;
      end else if (m_rem[k] == 0) begin
        if (seed_we) begin
          m16[k] = (seed_data == 16'hFFFF) ? 16'h0000 : seed_data;
          m8[k]  = seed_data[15:8] ^ seed_data[7:0];
          if (m8[k] == 8'hFF) m8[k] = 8'h00;
        end else if (req != 2'b00) begin
          if (req == 2'b11) m_g[k] = ~m_last[k];
          else              m_g[k] = (req == 2'b10);
          for (int s = 0; s < m_steps[k]; s++) begin
            m16[k] = adv16(m16[k]);
            m8[k]  = adv8(m8[k]);
          end
          m_pend[k] = form_byte(m16[k], m8[k]);
          m_rem[k]  = m_steps[k] + 1;
        end
      end else begin
        m_rem[k]--;
        if (m_rem[k] == 1) m_out[k] = m_pend[k];
        if (m_rem[k] == 0) m_last[k] = m_g[k];
      end
    end
  endtask

  task automatic check_all();
    logic [1:0] exp_ack;
    for (int k = 0; k < 2; k++) begin
      exp_ack = (m_rem[k] == 1) ? (m_g[k] ? 2'b10 : 2'b01) : 2'b00;
      check_eq(k == 0 ? "ack_s8" : "ack_s1", 16'(k == 0 ? ack_a : ack_b), 16'(exp_ack));
      check_eq(k == 0 ? "valid_s8" : "valid_s1", 16'(k == 0 ? val_a : val_b), 16'(m_rem[k] == 1));
      check_eq(k == 0 ? "busy_s8" : "busy_s1", 16'(k == 0 ? busy_a : busy_b), 16'(m_rem[k] != 0));
      check_eq(k == 0 ? "rnd_s8" : "rnd_s1", 16'(k == 0 ? rnd_a : rnd_b), 16'(m_out[k]));
    end
  endtask

  // One clock: apply inputs away from the edge, predict the edge, check after it.
  task automatic cyc(input logic r, input logic sw, input logic [15:0] sd, input logic [1:0] rq);
    rst_n = r; seed_we = sw; seed_data = sd; req = rq;
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  int ack_seen;

  initial begin
    cyc(1'b0, 1'b0, 16'h0, 2'b00);
    cyc(1'b0, 1'b0, 16'h0, 2'b00);

    // First delivery after reset; req drops mid-STEP and a seed_we lands during STEP.
    cyc(1'b1, 1'b0, 16'h0, 2'b01);
    for (int i = 0; i < 10; i++) cyc(1'b1, (i == 3), 16'hABCD, 2'b00);
    check_eq("first_byte_s8", 16'(rnd_a), 16'h000C);

    // Held tie: acks alternate starting with requester 0.
    cyc(1'b0, 1'b0, 16'h0, 2'b00);
    ack_seen = 0;
    for (int i = 0; i < 45; i++) begin
      cyc(1'b1, 1'b0, 16'h0, 2'b11);
      if (ack_a != 2'b00) begin
        check_eq("tie_order", 16'(ack_a), (ack_seen % 2 == 0) ? 16'h1 : 16'h2);
        ack_seen++;
      end
    end
    check_eq("tie_count", 16'(ack_seen), 16'd4);

    // Seed loads, including the lock-up value and a seed colliding with a request.
    for (int i = 0; i < 12; i++) cyc(1'b1, 1'b0, 16'h0, 2'b00);
    cyc(1'b1, 1'b1, 16'hFFFF, 2'b00);
    cyc(1'b1, 1'b1, 16'h1234, 2'b01);
    check_eq("seed_no_grant", 16'(busy_a), 16'h0);
    for (int i = 0; i < 12; i++) cyc(1'b1, 1'b0, 16'h0, (i == 0) ? 2'b01 : 2'b00);

    // Reset on the 4th STEP cycle, then the post-reset delivery must repeat.
    cyc(1'b1, 1'b0, 16'h0, 2'b01);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 16'h0, 2'b01);
    cyc(1'b0, 1'b0, 16'h0, 2'b00);
    check_eq("abort_ack", 16'(ack_a), 16'h0);
    cyc(1'b1, 1'b0, 16'h0, 2'b01);
    for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, 16'h0, 2'b00);
    check_eq("repeat_byte_s8", 16'(rnd_a), 16'h000C);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 59) != 0),
          ($urandom_range(0, 7) == 0),
          ($urandom_range(0, 9) == 0) ? 16'hFFFF : 16'($urandom),
          2'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
